// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between the core (master) and imem_responder (slave).
// Carries the fetch handshake, the response and the fence.i line-buffer invalidate.
interface imem_responder_if;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        inv;
  logic        imem_valid;
  logic        imem_rresp;
  logic [31:0] imem_rdata;

  modport master (
    output imem_ready, imem_addr, inv,
    input  imem_valid, imem_rresp, imem_rdata
  );

  modport slave (
    input  imem_ready, imem_addr, inv,
    output imem_valid, imem_rresp, imem_rdata
  );
endinterface

// File: rtl/imem_responder.sv
// Fetch responder over a 1-cycle synchronous SRAM; returns 32-bit windows at halfword granularity.
// Define IMEM_LINE_BUFFER_EN to let the one-word line buffer short-cut SRAM reads on a hit.
module imem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned RAM_AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_responder_if.slave       imem,
  output logic                  ram_req,
  output logic [RAM_AW-1:0]     ram_addr,
  input  logic [31:0]           ram_rdata
);

  localparam logic [RAM_AW-1:0] AwOne = RAM_AW'(1);

  typedef enum logic [1:0] {StIdle, StRdLo, StRdHi, StResp} state_e;

  state_e             r_state, w_state_d;
  logic [RAM_AW-1:0]  r_n, w_n_d;
  logic               r_h, w_h_d;
  logic [31:0]        r_bdata, w_bdata_d;
  logic [31:0]        r_rdata, w_rdata_d;
  logic               r_rresp, w_rresp_d;

  logic [29:0]        w_n;
  logic               w_h;
  logic               w_err;
  logic               w_hit;

  // Modulo subtraction: addresses below ADDR_BASE wrap to a huge N and fall into the error case.
  assign w_n   = 30'((imem.imem_addr - ADDR_BASE) >> 2);
  assign w_h   = imem.imem_addr[1];
  assign w_err = imem.imem_addr[0]
              || ({2'b00, w_n} >= DEPTH)
              || (w_h && (({2'b00, w_n} + 32'd1) >= DEPTH));

`ifdef IMEM_LINE_BUFFER_EN
  logic              r_bvalid, w_bvalid_d;
  logic [RAM_AW-1:0] r_btag, w_btag_d;

  assign w_hit = r_bvalid && (r_btag == w_n[RAM_AW-1:0]) && !imem.inv;

  // inv wins over a same-cycle buffer write, so the buffer ends invalid.
  always_comb begin
    w_bvalid_d = r_bvalid;
    w_btag_d   = r_btag;
    if (r_state == StRdLo) begin
      w_bvalid_d = 1'b1;
      w_btag_d   = r_n;
    end else if (r_state == StRdHi) begin
      w_bvalid_d = 1'b1;
      w_btag_d   = r_n + AwOne;
    end
    if (imem.inv) w_bvalid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bvalid <= 1'b0;
      r_btag   <= '0;
    end else begin
      r_bvalid <= w_bvalid_d;
      r_btag   <= w_btag_d;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_h     <= 1'b0;
      r_bdata <= '0;
      r_rdata <= '0;
      r_rresp <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_n     <= w_n_d;
      r_h     <= w_h_d;
      r_bdata <= w_bdata_d;
      r_rdata <= w_rdata_d;
      r_rresp <= w_rresp_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_d = r_state;
    w_n_d     = r_n;
    w_h_d     = r_h;
    w_bdata_d = r_bdata;
    w_rdata_d = r_rdata;
    w_rresp_d = r_rresp;
    unique case (r_state)
      StIdle: begin
        if (imem.imem_ready) begin
          w_n_d = w_n[RAM_AW-1:0];
          w_h_d = w_h;
          if (w_err) begin
            w_state_d = StResp;
            w_rresp_d = 1'b0;
            w_rdata_d = '0;
          end else if (w_hit && !w_h) begin
            w_state_d = StResp;
            w_rresp_d = 1'b1;
            w_rdata_d = r_bdata;
          end else if (w_hit) begin
            w_state_d = StRdHi;
          end else begin
            w_state_d = StRdLo;
          end
        end
      end
      StRdLo: begin
        w_bdata_d = ram_rdata;
        if (r_h) begin
          w_state_d = StRdHi;
        end else begin
          w_state_d = StResp;
          w_rresp_d = 1'b1;
          w_rdata_d = ram_rdata;
        end
      end
      StRdHi: begin
        w_bdata_d = ram_rdata;
        w_rdata_d = {ram_rdata[15:0], r_bdata[31:16]};
        w_rresp_d = 1'b1;
        w_state_d = StResp;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs: SRAM request is combinational in the issuing cycle, response comes from registers.
  always_comb begin
    ram_req  = 1'b0;
    ram_addr = '0;
    if (!reset) begin
      if (r_state == StIdle && imem.imem_ready && !w_err && !(w_hit && !w_h)) begin
        ram_req  = 1'b1;
        ram_addr = w_hit ? (w_n[RAM_AW-1:0] + AwOne) : w_n[RAM_AW-1:0];
      end else if (r_state == StRdLo && r_h) begin
        ram_req  = 1'b1;
        ram_addr = r_n + AwOne;
      end
    end
    imem.imem_valid = (r_state == StResp);
    imem.imem_rresp = r_rresp;
    imem.imem_rdata = r_rdata;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder with a behavioural 1-cycle SRAM.
// Expectations follow the IMEM_LINE_BUFFER_EN build setting.
module tb_imem_responder;

  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned RAM_AW = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              ram_req;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic [31:0]       ram [0:DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;

  imem_responder_if bus ();

  imem_responder #(
    .ADDR_BASE (32'h0000_0000),
    .DEPTH     (DEPTH),
    .RAM_AW    (RAM_AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (bus),
    .ram_req   (ram_req),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_req) ram_rdata <= ram[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One fetch; cycle 0 is the accept cycle. Records every ram_req until imem_valid.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic iv,
                       input int exp_lat, input logic exp_rresp, input logic [31:0] exp_rdata,
                       input int exp_nreq, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int          lat;
    int          nreq;
    logic [31:0] req_a [4];
    logic        got_rresp;
    logic [31:0] got_rdata;
    lat       = -1;
    nreq      = 0;
    got_rresp = 1'bx;
    got_rdata = 'x;
    @(negedge clk);
    bus.imem_ready = 1'b1;
    bus.imem_addr  = addr;
    bus.inv        = iv;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (ram_req) begin
        if (nreq < 4) req_a[nreq] = 32'(ram_addr);
        nreq++;
      end
      if (bus.imem_valid) begin
        lat       = k;
        got_rresp = bus.imem_rresp;
        got_rdata = bus.imem_rdata;
        break;
      end
      @(negedge clk);
      bus.inv = 1'b0;
    end
    bus.imem_ready = 1'b0;
    bus.inv        = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rresp"}, {31'b0, got_rresp}, {31'b0, exp_rresp});
    check_eq({tag, "_rdata"}, got_rdata, exp_rdata);
    check_eq({tag, "_nreq"}, 32'(nreq), 32'(exp_nreq));
    if (exp_nreq >= 1 && nreq >= 1) check_eq({tag, "_ramaddr0"}, req_a[0], exp_a0);
    if (exp_nreq >= 2 && nreq >= 2) check_eq({tag, "_ramaddr1"}, req_a[1], exp_a1);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = 32'h0;
    ram[0]    = 32'h0000_0013;
    ram[1]    = 32'hAAAA_BBBB;
    ram[2]    = 32'hCCCC_DDDD;
    ram[3]    = 32'h1111_2222;
    ram[4095] = 32'h5A5A_0FF0;
    bus.imem_ready = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.inv        = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", {31'b0, bus.imem_valid}, 32'h0);
    check_eq("rst_rresp", {31'b0, bus.imem_rresp}, 32'h0);
    check_eq("rst_rdata", bus.imem_rdata, 32'h0);
    check_eq("rst_ramreq", {31'b0, ram_req}, 32'h0);
    check_eq("rst_ramaddr", 32'(ram_addr), 32'h0);
    reset = 1'b0;

    fetch("t1_miss", 32'h0, 1'b0, 2, 1'b1, 32'h0000_0013, 1, 32'd0, 32'd0);
`ifdef IMEM_LINE_BUFFER_EN
    fetch("t2_hit", 32'h0, 1'b0, 1, 1'b1, 32'h0000_0013, 0, 32'd0, 32'd0);
`else
    fetch("t2_nobuf", 32'h0, 1'b0, 2, 1'b1, 32'h0000_0013, 1, 32'd0, 32'd0);
`endif
    fetch("t3_strad_miss", 32'h6, 1'b0, 3, 1'b1, 32'hDDDD_AAAA, 2, 32'd1, 32'd2);
`ifdef IMEM_LINE_BUFFER_EN
    fetch("t4_strad_hit", 32'hA, 1'b0, 2, 1'b1, 32'h2222_CCCC, 1, 32'd3, 32'd0);
`else
    fetch("t4_strad_nobuf", 32'hA, 1'b0, 3, 1'b1, 32'h2222_CCCC, 2, 32'd2, 32'd3);
`endif
    fetch("t5_odd", 32'h1, 1'b0, 1, 1'b0, 32'h0, 0, 32'd0, 32'd0);
    fetch("t5_last_word", 32'h3FFC, 1'b0, 2, 1'b1, 32'h5A5A_0FF0, 1, 32'd4095, 32'd0);
    fetch("t5_strad_end", 32'h3FFE, 1'b0, 1, 1'b0, 32'h0, 0, 32'd0, 32'd0);
    fetch("t5_past_end", 32'h4000, 1'b0, 1, 1'b0, 32'h0, 0, 32'd0, 32'd0);
    fetch("t5_wrap", 32'hFFFF_FFFC, 1'b0, 1, 1'b0, 32'h0, 0, 32'd0, 32'd0);

    // Straddle miss at 0x6 (buffer holds word 4095), reset asserted while in RD_HI.
    @(negedge clk);
    bus.imem_ready = 1'b1;
    bus.imem_addr  = 32'h6;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_valid", {31'b0, bus.imem_valid}, 32'h0);
    check_eq("t6_rst_rresp", {31'b0, bus.imem_rresp}, 32'h0);
    check_eq("t6_rst_rdata", bus.imem_rdata, 32'h0);
    check_eq("t6_rst_ramreq", {31'b0, ram_req}, 32'h0);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    reset          = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        #1;
        if (bus.imem_valid) seen++;
      end
      check_eq("t6_no_valid", 32'(seen), 32'd0);
    end
    fetch("t6_inv_fetch", 32'h8, 1'b1, 2, 1'b1, 32'hCCCC_DDDD, 1, 32'd2, 32'd0);
`ifdef IMEM_LINE_BUFFER_EN
    fetch("t7_hit_again", 32'h8, 1'b0, 1, 1'b1, 32'hCCCC_DDDD, 0, 32'd0, 32'd0);
    fetch("t7_inv_miss", 32'h8, 1'b1, 2, 1'b1, 32'hCCCC_DDDD, 1, 32'd2, 32'd0);
`else
    fetch("t7_nobuf", 32'h8, 1'b0, 2, 1'b1, 32'hCCCC_DDDD, 1, 32'd2, 32'd0);
`endif
    fetch("t8_strad_lo", 32'h2, 1'b0, 3, 1'b1, 32'hBBBB_0000, 2, 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
